sol6b_sweep: RTL and testbench

- Upstream stimulus-and-capture stage for the 4-input combinational block `sol6b`.
- Drives `sol6b` inputs A,B,C,D through all 16 combinations in order {A,B,C,D} = 0..15 and waits a programmable settle time for each one.
- Samples `sol6b` output H into a 16-bit truth-table register and flags whether the captured table matches a golden value.
- Used on the board/bench as a self-checking wrapper around `sol6b`.

---
 rtl/sol6b_sweep.sv | 117 +++++++++++
 tb/tb_sol6b_sweep.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sol6b_sweep.sv
// sol6b_sweep: stimulus-and-capture wrapper for the 4-input combinational block sol6b.
// Walks {A,B,C,D} through 0..15, holds each vector SETTLE cycles plus one capture
// cycle, stores H into a 16-bit truth table and compares it against EXPECTED.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_start  sweep request, only honoured in IDLE
//   i_h      H output of sol6b
//   o_a..o_d stimulus bits 3..0 of the vector index (registered)
//   o_busy   high during SETTLE/CAPTURE
//   o_done   one-cycle pulse in FINISH
//   o_table  captured truth table, bit i = H for vector i
//   o_pass   o_table == EXPECTED, valid from o_done until the next start
//
// Port "table" is a reserved word in SystemVerilog, so all ports carry i_/o_ prefixes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for i_start; table/pass hold last sweep's result
// SETTLE  | current vector applied, counting SETTLE cycles
// CAPTURE | last cycle of the vector window; H stored at its ending edge
// FINISH  | one cycle, done pulse, pass valid

module sol6b_sweep #(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h0FCD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_h,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic        o_d,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_table,
    output logic        o_pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_table;
    logic        r_pass;
    logic [15:0] w_table_cap;

    // Table as it will look after the capture edge; also used so that pass is
    // already valid during the FINISH cycle.
    always_comb begin
        w_table_cap        = r_table;
        w_table_cap[r_idx] = i_h;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_next = S_SETTLE;
            S_SETTLE:  if (r_cnt == SETTLE_LAST) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = (r_idx == 4'd15) ? S_FINISH : S_SETTLE;
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_table <= 16'h0000;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_idx   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_table <= 16'h0000;
                        r_pass  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) r_cnt <= 4'd0;
                    else                      r_cnt <= r_cnt + 4'd1;
                end
                S_CAPTURE: begin
                    r_table <= w_table_cap;
                    // idx stays at 15 through FINISH so the last vector remains applied
                    if (r_idx == 4'd15) r_pass <= (w_table_cap == EXPECTED);
                    else                r_idx  <= r_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign {o_a, o_b, o_c, o_d} = r_idx;
    assign o_busy  = (r_state == S_SETTLE) || (r_state == S_CAPTURE);
    assign o_done  = (r_state == S_FINISH);
    assign o_table = r_table;
    assign o_pass  = r_pass;

endmodule

// File: tb/tb_sol6b_sweep.sv
module tb_sol6b_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [1:0]  hmode = 2'd0;   // 0 golden sol6b, 1 stuck-at-0, 2 inverted
    logic [15:0] gold = 16'h0FCD;

    logic        a0, b0, c0, d0, busy0, done0, pass0, h0;
    logic        a1, b1, c1, d1, busy1, done1, pass1, h1;
    logic [15:0] tbl0, tbl1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural sol6b models
    assign h0 = (hmode == 2'd0) ? gold[{a0, b0, c0, d0}] :
                (hmode == 2'd1) ? 1'b0 : ~gold[{a0, b0, c0, d0}];
    assign h1 = gold[{a1, b1, c1, d1}];

    sol6b_sweep #(.SETTLE(2), .EXPECTED(16'h0FCD)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_h(h0),
        .o_a(a0), .o_b(b0), .o_c(c0), .o_d(d0),
        .o_busy(busy0), .o_done(done0), .o_table(tbl0), .o_pass(pass0)
    );

    sol6b_sweep #(.SETTLE(1), .EXPECTED(16'h0FCD)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_h(h1),
        .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1),
        .o_busy(busy1), .o_done(done1), .o_table(tbl1), .o_pass(pass1)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] exp_table;
        logic        exp_pass;
        int          pa;
        int          pb;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h required %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] abcd(input int sel);
        return (sel == 0) ? {a0, b0, c0, d0} : {a1, b1, c1, d1};
    endfunction
    function automatic logic busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction
    function automatic logic pass(input int sel);
        return (sel == 0) ? pass0 : pass1;
    endfunction
    function automatic logic [15:0] tbl(input int sel);
        return (sel == 0) ? tbl0 : tbl1;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // One complete sweep with per-cycle checks; pa/pb are cycles with extra start pulses.
    task automatic sweep(input int sel, input int s, input logic [15:0] et, input logic ep,
                         input int pa, input int pb);
        int last;
        last = 16 * (s + 1);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        for (int k = 1; k <= last + 2; k++) begin
            set_start(sel, (k == pa) || (k == pb));
            if (k == 1) chk("pass_cleared_on_start", 32'(pass(sel)), 32'd0);
            if (k <= last) begin
                chk("busy_during_sweep", 32'(busy(sel)), 32'd1);
                chk("no_early_done", 32'(done(sel)), 32'd0);
                chk("abcd_step", 32'(abcd(sel)), 32'((k - 1) / (s + 1)));
            end else if (k == last + 1) begin
                chk("done_at_latency", 32'(done(sel)), 32'd1);
                chk("busy_low_in_finish", 32'(busy(sel)), 32'd0);
                chk("abcd_finish_15", 32'(abcd(sel)), 32'd15);
                chk("table_final", 32'(tbl(sel)), 32'(et));
                chk("pass_final", 32'(pass(sel)), 32'(ep));
            end else begin
                chk("done_one_cycle", 32'(done(sel)), 32'd0);
                chk("idle_not_busy", 32'(busy(sel)), 32'd0);
                chk("table_holds", 32'(tbl(sel)), 32'(et));
                chk("pass_holds", 32'(pass(sel)), 32'(ep));
            end
            tick();
        end
        set_start(sel, 1'b0);
    endtask

    initial begin
        int ndone;
        vecs[0] = '{mode: 2'd0, exp_table: 16'h0FCD, exp_pass: 1'b1, pa: 0, pb: 0};
        vecs[1] = '{mode: 2'd1, exp_table: 16'h0000, exp_pass: 1'b0, pa: 0, pb: 0};
        vecs[2] = '{mode: 2'd2, exp_table: 16'hF032, exp_pass: 1'b0, pa: 0, pb: 0};
        vecs[3] = '{mode: 2'd0, exp_table: 16'h0FCD, exp_pass: 1'b1, pa: 5, pb: 30};

        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("idle_outputs0", {busy0, done0, pass0, a0, b0, c0, d0, tbl0}, 32'd0);
            chk("idle_outputs1", {busy1, done1, pass1, a1, b1, c1, d1, tbl1}, 32'd0);
            tick();
        end

        // Table-driven sweeps on the SETTLE=2 instance
        for (int i = 0; i < 4; i++) begin
            hmode = vecs[i].mode;
            sweep(0, 2, vecs[i].exp_table, vecs[i].exp_pass, vecs[i].pa, vecs[i].pb);
        end
        hmode = 2'd0;

        // Held start: next sweep's busy rises two cycles after done
        start0 = 1'b1;
        tick();
        for (int k = 1; k <= 51; k++) begin
            if (k == 49) chk("held_done", 32'(done0), 32'd1);
            if (k == 50) chk("held_idle_gap", {busy0, done0}, 32'd0);
            if (k == 51) begin
                chk("held_restart_busy", 32'(busy0), 32'd1);
                chk("held_restart_idx0", 32'({a0, b0, c0, d0}), 32'd0);
            end
            tick();
        end
        start0 = 1'b0;

        // Reset mid-sweep (previous sweep is still running; reset clears it too)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy0), 32'd0);
        chk("rst_mid_table", 32'(tbl0), 32'd0);
        chk("rst_mid_abcd", 32'({a0, b0, c0, d0}), 32'd0);
        chk("rst_mid_done_pass", {done0, pass0}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            if (done0 || busy0) ndone++;
            tick();
        end
        chk("rst_mid_no_activity", 32'(ndone), 32'd0);
        sweep(0, 2, 16'h0FCD, 1'b1, 0, 0);

        // rst and start on the same edge: rst wins
        rst = 1'b1;
        start0 = 1'b1;
        tick();
        rst = 1'b0;
        start0 = 1'b0;
        chk("rst_beats_start", 32'(busy0), 32'd0);
        tick();
        chk("rst_beats_start_after", 32'(busy0), 32'd0);

        // SETTLE=1 instance
        sweep(1, 1, 16'h0FCD, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
